rs_slot_alloc: RTL and testbench

- Dispatch-side counterpart of the RS issue selectors. It tracks occupancy of the reservation-station slots and grants up to two free slots per cycle to the dispatch lanes.
- Issue-stage grants free slots; a squash empties the RS.
- Sits between the dispatch stage and the RS entry array. Its one-hot slot grants drive the entry write enables.

---
 rtl/rs_slot_alloc.sv | 120 ++++++++++++
 tb/tb_rs_slot_alloc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_slot_alloc.sv
// rs_slot_alloc
// -----------------------------------------------------------------------------
// Tracks occupancy of the reservation-station slots and grants up to two free
// slots per cycle to the dispatch lanes. Slots are freed by the issue stage
// one cycle after their grant, and a squash empties the whole RS.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset (deassertion synchronised outside)
//   disp_req    dispatch lane valid, [0] is the older lane
//   issue_gnt   slots issued this cycle (may be multi-hot)
//   squash      branch mispredict, empties the RS
//   alloc_gnt0  one-hot slot granted to lane 0, or zero
//   alloc_gnt1  one-hot slot granted to lane 1, or zero
//   disp_ack    per-lane accept (same-cycle handshake)
//   busy        registered slot-occupied bitmap
//   free_cnt    number of free slots
//   stall       advisory, high when fewer than two slots are free
//   err         sticky flag: an issue grant hit a slot that was not busy
// -----------------------------------------------------------------------------
module rs_slot_alloc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       disp_req,
    input  logic [WIDTH-1:0] issue_gnt,
    input  logic             squash,
    output logic [WIDTH-1:0] alloc_gnt0,
    output logic [WIDTH-1:0] alloc_gnt1,
    output logic [1:0]       disp_ack,
    output logic [WIDTH-1:0] busy,
    output logic [CNT_W-1:0] free_cnt,
    output logic             stall,
    output logic             err
);

    // Isolate the lowest-index set bit (two's-complement trick).
    function automatic logic [WIDTH-1:0] lowest_bit(input logic [WIDTH-1:0] vec);
        return vec & (~vec + {{(WIDTH-1){1'b0}}, 1'b1});
    endfunction

    // Count the set bits of a vector.
    function automatic logic [CNT_W-1:0] pop_count(input logic [WIDTH-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    logic [WIDTH-1:0] busy_r;
    logic             err_r;
    logic [WIDTH-1:0] free_s;
    logic [WIDTH-1:0] gnt0_s;
    logic [WIDTH-1:0] gnt1_s;
    logic [WIDTH-1:0] busy_next_s;
    logic             err_hit_s;

    // Grant selection. Slots freed by this cycle's issue_gnt are not visible
    // here on purpose: free is taken from the registered bitmap only.
    always_comb begin
        free_s = ~busy_r;
        gnt0_s = {WIDTH{1'b0}};
        gnt1_s = {WIDTH{1'b0}};
        if (!squash && disp_req[0]) begin
            gnt0_s = lowest_bit(free_s);
        end else begin
            gnt0_s = {WIDTH{1'b0}};
        end
        // Lane 1 may only go when the older lane is either idle or accepted,
        // and never takes the slot just handed to lane 0.
        if (!squash && disp_req[1] && (!disp_req[0] || (|gnt0_s))) begin
            gnt1_s = lowest_bit(free_s & ~gnt0_s);
        end else begin
            gnt1_s = {WIDTH{1'b0}};
        end
    end

    // Next-state bitmap and error detection.
    always_comb begin
        err_hit_s = |(issue_gnt & ~busy_r);
        if (squash) begin
            busy_next_s = {WIDTH{1'b0}};
        end else begin
            busy_next_s = (busy_r & ~issue_gnt) | gnt0_s | gnt1_s;
        end
    end

    // Occupancy register; squash has already been folded into busy_next_s.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= {WIDTH{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Sticky error flag; only reset clears it, squash does not.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else if (err_hit_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign alloc_gnt0 = gnt0_s;
    assign alloc_gnt1 = gnt1_s;
    assign disp_ack   = {|gnt1_s, |gnt0_s};
    assign busy       = busy_r;
    assign free_cnt   = pop_count(free_s);
    assign stall      = (free_cnt < CNT_W'(2));
    assign err        = err_r;

endmodule

// File: tb/tb_rs_slot_alloc.sv
// Self-checking bench for rs_slot_alloc: a slot-list model predicts every
// output each cycle, and directed scenarios pin the model with literals.
module tb_rs_slot_alloc;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  disp_req = 2'b00;
    logic [15:0] issue_gnt = 16'h0000;
    logic        squash = 1'b0;
    logic [15:0] alloc_gnt0;
    logic [15:0] alloc_gnt1;
    logic [1:0]  disp_ack;
    logic [15:0] busy;
    logic [4:0]  free_cnt;
    logic        stall;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_busy = 16'h0000;
    logic        m_err  = 1'b0;

    rs_slot_alloc #(.WIDTH(16), .CNT_W(5)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .disp_req   (disp_req),
        .issue_gnt  (issue_gnt),
        .squash     (squash),
        .alloc_gnt0 (alloc_gnt0),
        .alloc_gnt1 (alloc_gnt1),
        .disp_ack   (disp_ack),
        .busy       (busy),
        .free_cnt   (free_cnt),
        .stall      (stall),
        .err        (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list the free slot indices in ascending order, hand the first
    // to the older lane and the next to the younger one.
    function automatic logic [31:0] model_grants(input logic [15:0] b, input logic [1:0] rq,
                                                 input logic sq);
        int f0 = -1;
        int f1 = -1;
        logic [15:0] g0 = 16'h0000;
        logic [15:0] g1 = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (!b[i]) begin
                if (f0 < 0) f0 = i;
                else if (f1 < 0) f1 = i;
            end
        end
        if (!sq) begin
            if (rq[0]) begin
                if (f0 >= 0) g0[f0] = 1'b1;
                if (rq[1] && f1 >= 0) g1[f1] = 1'b1;
            end else if (rq[1] && f0 >= 0) begin
                g1[f0] = 1'b1;
            end
        end
        return {g1, g0};
    endfunction

    function automatic int model_free(input logic [15:0] b);
        int n = 0;
        for (int i = 0; i < 16; i++) if (!b[i]) n++;
        return n;
    endfunction

    // Model state update at each active edge (and immediately on reset).
    always @(posedge clock or negedge reset_n) begin
        logic [31:0] g;
        if (!reset_n) begin
            m_busy <= 16'h0000;
            m_err  <= 1'b0;
        end else begin
            g = model_grants(m_busy, disp_req, squash);
            m_err <= m_err | (|(issue_gnt & ~m_busy));
            if (squash) m_busy <= 16'h0000;
            else        m_busy <= (m_busy & ~issue_gnt) | g[15:0] | g[31:16];
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        logic [31:0] g;
        int nf;
        g  = model_grants(m_busy, disp_req, squash);
        nf = model_free(m_busy);
        check("cyc_gnt0", 32'(alloc_gnt0), 32'(g[15:0]));
        check("cyc_gnt1", 32'(alloc_gnt1), 32'(g[31:16]));
        check("cyc_ack", 32'(disp_ack), {30'd0, |g[31:16], |g[15:0]});
        check("cyc_busy", 32'(busy), 32'(m_busy));
        check("cyc_free_cnt", 32'(free_cnt), 32'(nf));
        check("cyc_stall", 32'(stall), (nf < 2) ? 32'd1 : 32'd0);
        check("cyc_err", 32'(err), 32'(m_err));
    end

    // Apply one cycle of inputs just after the active edge.
    task automatic drive(input logic [1:0] rq, input logic [15:0] iss, input logic sq);
        @(posedge clock);
        #1;
        disp_req  = rq;
        issue_gnt = iss;
        squash    = sq;
    endtask

    // Reach an arbitrary busy pattern: empty, fill, then issue the holes.
    task automatic set_busy(input logic [15:0] target);
        drive(2'b00, 16'h0000, 1'b1);
        for (int k = 0; k < 8; k++) drive(2'b11, 16'h0000, 1'b0);
        drive(2'b00, ~target, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_free_cnt", 32'(free_cnt), 32'd16);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_gnt0", 32'(alloc_gnt0), 32'h0);
        #14;
        reset_n = 1'b1;

        // Fill: pairs of slots per cycle
        for (int k = 0; k < 8; k++) begin
            drive(2'b11, 16'h0000, 1'b0);
            #1;
            check("fill_gnt0", 32'(alloc_gnt0), 32'h1 << (2 * k));
            check("fill_gnt1", 32'(alloc_gnt1), 32'h1 << (2 * k + 1));
            check("fill_ack", 32'(disp_ack), 32'd3);
        end
        drive(2'b11, 16'h0000, 1'b0);
        #1;
        check("full_busy", 32'(busy), 32'hFFFF);
        check("full_stall", 32'(stall), 32'd1);
        check("full_ack", 32'(disp_ack), 32'd0);
        check("full_free_cnt", 32'(free_cnt), 32'd0);

        // One free slot, both lanes request
        set_busy(16'hFFFE);
        drive(2'b11, 16'h0000, 1'b0);
        #1;
        check("one_gnt0", 32'(alloc_gnt0), 32'h0001);
        check("one_gnt1", 32'(alloc_gnt1), 32'h0000);
        check("one_ack", 32'(disp_ack), 32'd1);
        check("one_stall", 32'(stall), 32'd1);

        // No bypass of freshly issued slots
        set_busy(16'hFFFF);
        drive(2'b11, 16'h0028, 1'b0);
        #1;
        check("nobyp_ack", 32'(disp_ack), 32'd0);
        drive(2'b11, 16'h0000, 1'b0);
        #1;
        check("nobyp_busy", 32'(busy), 32'hFFD7);
        check("nobyp_gnt0", 32'(alloc_gnt0), 32'h0008);
        check("nobyp_gnt1", 32'(alloc_gnt1), 32'h0020);

        // Lane 1 alone
        set_busy(16'h00FF);
        drive(2'b10, 16'h0000, 1'b0);
        #1;
        check("l1_gnt0", 32'(alloc_gnt0), 32'h0000);
        check("l1_gnt1", 32'(alloc_gnt1), 32'h0100);
        check("l1_ack", 32'(disp_ack), 32'd2);
        drive(2'b00, 16'h0000, 1'b0);
        #1;
        check("l1_busy", 32'(busy), 32'h01FF);

        // Squash beats issue and allocation
        set_busy(16'h0F0F);
        drive(2'b11, 16'h0001, 1'b1);
        #1;
        check("sq_ack", 32'(disp_ack), 32'd0);
        drive(2'b00, 16'h0000, 1'b0);
        #1;
        check("sq_busy", 32'(busy), 32'h0);
        check("sq_free_cnt", 32'(free_cnt), 32'd16);
        check("sq_err", 32'(err), 32'd0);

        // Sticky error, then asynchronous reset mid-cycle
        set_busy(16'h0001);
        drive(2'b00, 16'h0002, 1'b0);
        drive(2'b00, 16'h0000, 1'b0);
        #1;
        check("err_set", 32'(err), 32'd1);
        drive(2'b11, 16'h0000, 1'b0);
        drive(2'b01, 16'h0001, 1'b0);
        drive(2'b00, 16'h0000, 1'b1);
        #1;
        check("err_sticky", 32'(err), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_err", 32'(err), 32'd0);
        drive(2'b11, 16'h0000, 1'b0);
        reset_n = 1'b1;
        drive(2'b11, 16'h0000, 1'b0);
        #1;
        check("post_gnt0", 32'(alloc_gnt0), 32'h0004);
        drive(2'b00, 16'h0000, 1'b0);
        drive(2'b00, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
